// File: rtl/reset_seq_if.sv
// Sideband bundle between the reset sequencer and the rest of the system.
// The slave side is the sequencer; the master side is the system/bench.
interface reset_seq_if;
    logic mem_ready;
    logic soft_rst_req;
    logic rst_mem;
    logic rst_periph;
    logic rst_cpu;
    logic seq_done;
    logic timeout;

    modport master (
        output mem_ready,
        output soft_rst_req,
        input  rst_mem,
        input  rst_periph,
        input  rst_cpu,
        input  seq_done,
        input  timeout
    );

    modport slave (
        input  mem_ready,
        input  soft_rst_req,
        output rst_mem,
        output rst_periph,
        output rst_cpu,
        output seq_done,
        output timeout
    );
endinterface

// File: rtl/reset_seq.sv
// Staged reset sequencer: releases memory, then peripherals, then CPU, after the
// debounced board reset drops; also services warm resets that keep memory alive.
module reset_seq #(
    parameter int unsigned STAGE_GAP       = 16,
    parameter int unsigned INIT_TIMEOUT    = 4096,
    parameter int unsigned SOFT_RST_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    reset_seq_if.slave  bus
);

    localparam int unsigned CNT_W = 16;

    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SOFT_LAST = CNT_W'(SOFT_RST_CYCLES - 1);

    typedef enum logic [2:0] {
        S_HOLD     = 3'd0,
        S_MEM      = 3'd1,
        S_WAIT_MEM = 3'd2,
        S_PERIPH   = 3'd3,
        S_RUN      = 3'd4,
        S_SOFT     = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             rst_mem_q, rst_periph_q, rst_cpu_q, seq_done_q;

    // Next-state, stage counter and sticky timeout.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        timeout_d = timeout_q;

        unique case (state_q)
            S_HOLD: begin
                state_d = S_MEM;
            end
            S_MEM: begin
                if (cnt_q == GAP_LAST) state_d = S_WAIT_MEM;
            end
            S_WAIT_MEM: begin
                // A ready SDRAM on the final wait cycle wins over the timeout.
                if (bus.mem_ready) begin
                    state_d = S_PERIPH;
                end else if (cnt_q == INIT_LAST) begin
                    state_d   = S_PERIPH;
                    timeout_d = 1'b1;
                end
            end
            S_PERIPH: begin
                if (cnt_q == GAP_LAST) state_d = S_RUN;
            end
            S_RUN: begin
                cnt_d = cnt_q;
                if (bus.soft_rst_req) state_d = S_SOFT;
            end
            S_SOFT: begin
                if (cnt_q == SOFT_LAST) state_d = S_PERIPH;
            end
            default: begin
                state_d = S_HOLD;
            end
        endcase

        if (state_d != state_q) cnt_d = '0;
    end

    // State register with outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_HOLD;
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
            rst_mem_q    <= 1'b1;
            rst_periph_q <= 1'b1;
            rst_cpu_q    <= 1'b1;
            seq_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            timeout_q    <= timeout_d;
            rst_mem_q    <= (state_d == S_HOLD);
            rst_periph_q <= (state_d == S_HOLD) || (state_d == S_MEM) ||
                            (state_d == S_WAIT_MEM) || (state_d == S_SOFT);
            rst_cpu_q    <= (state_d != S_RUN);
            seq_done_q   <= (state_d == S_RUN);
        end
    end

    assign bus.rst_mem    = rst_mem_q;
    assign bus.rst_periph = rst_periph_q;
    assign bus.rst_cpu    = rst_cpu_q;
    assign bus.seq_done   = seq_done_q;
    assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_reset_seq.sv
// Bench for reset_seq: a deadline-based model of the release schedule is compared
// against the DUT every cycle, plus literal timing points around each transition.
module tb_reset_seq;

    localparam int unsigned STAGE_GAP       = 16;
    localparam int unsigned INIT_TIMEOUT    = 4096;
    localparam int unsigned SOFT_RST_CYCLES = 32;

    // Model phases and the reset pattern {rst_mem, rst_periph, rst_cpu, seq_done} each drives.
    localparam int P_HOLD = 0, P_MEM = 1, P_WAIT = 2, P_PERIPH = 3, P_RUN = 4, P_SOFT = 5;
    logic [3:0] phase_out [6] = '{4'b1110, 4'b0110, 4'b0110, 4'b0010, 4'b0001, 4'b0110};

    logic clk = 1'b0;
    logic rst;

    reset_seq_if bus ();

    reset_seq #(
        .STAGE_GAP      (STAGE_GAP),
        .INIT_TIMEOUT   (INIT_TIMEOUT),
        .SOFT_RST_CYCLES(SOFT_RST_CYCLES)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;
    int   e0     = 0;
    int   ph     = P_HOLD;
    int   t_enter = 0;
    logic m_to   = 1'b0;
    logic m_valid = 1'b0;

    // Reference: each stage ends a fixed number of edges after it was entered.
    always @(posedge clk) begin
        edge_n = edge_n + 1;
        if (rst) begin
            ph = P_HOLD; t_enter = edge_n; m_to = 1'b0;
        end else begin
            case (ph)
                P_HOLD: begin ph = P_MEM; t_enter = edge_n; end
                P_MEM: if (edge_n - t_enter == STAGE_GAP) begin ph = P_WAIT; t_enter = edge_n; end
                P_WAIT: begin
                    if (bus.mem_ready) begin
                        ph = P_PERIPH; t_enter = edge_n;
                    end else if (edge_n - t_enter == INIT_TIMEOUT) begin
                        ph = P_PERIPH; t_enter = edge_n; m_to = 1'b1;
                    end
                end
                P_PERIPH: if (edge_n - t_enter == STAGE_GAP) begin ph = P_RUN; t_enter = edge_n; end
                P_RUN: if (bus.soft_rst_req) begin ph = P_SOFT; t_enter = edge_n; end
                P_SOFT: if (edge_n - t_enter == SOFT_RST_CYCLES) begin ph = P_PERIPH; t_enter = edge_n; end
                default: ph = P_HOLD;
            endcase
        end
        m_valid = 1'b1;
    end

    // Every-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (m_valid) begin
            logic [4:0] got, exp;
            got = {bus.rst_mem, bus.rst_periph, bus.rst_cpu, bus.seq_done, bus.timeout};
            exp = {phase_out[ph], m_to};
            checks = checks + 1;
            if (got !== exp) begin
                errors = errors + 1;
                $display("FAIL model_cmp edge=%0d got=%b expected=%b", edge_n, got, exp);
            end
        end
    end

    task automatic chk(input string name, input logic act, input logic exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s edge=%0d got=%b expected=%b", name, edge_n, act, exp);
        end
    endtask

    // Park on the negedge following absolute edge t.
    task automatic wait_abs(input int t);
        if (edge_n > t) begin
            errors = errors + 1;
            $display("FAIL wait_abs edge=%0d already past target=%0d", edge_n, t);
        end
        while (edge_n < t) @(negedge clk);
    endtask

    task automatic at(input int k);
        wait_abs(e0 + k);
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b0;
        e0 = edge_n + 1;
    endtask

    task automatic assert_rst(input string name);
        rst = 1'b1;
        @(negedge clk);
        chk({name, "_mem"},    bus.rst_mem,    1'b1);
        chk({name, "_periph"}, bus.rst_periph, 1'b1);
        chk({name, "_cpu"},    bus.rst_cpu,    1'b1);
        chk({name, "_done"},   bus.seq_done,   1'b0);
        chk({name, "_to"},     bus.timeout,    1'b0);
    endtask

    task automatic pulse_soft(output int s);
        s = edge_n + 1;
        bus.soft_rst_req = 1'b1;
        @(negedge clk);
        bus.soft_rst_req = 1'b0;
    endtask

    task automatic check_powerup();
        at(0);  chk("pu_mem_e0", bus.rst_mem, 1'b0);  chk("pu_periph_e0", bus.rst_periph, 1'b1);
        at(16); chk("pu_periph_e16", bus.rst_periph, 1'b1);
        at(17); chk("pu_periph_e17", bus.rst_periph, 1'b0); chk("pu_cpu_e17", bus.rst_cpu, 1'b1);
        at(32); chk("pu_cpu_e32", bus.rst_cpu, 1'b1);  chk("pu_done_e32", bus.seq_done, 1'b0);
        at(33); chk("pu_cpu_e33", bus.rst_cpu, 1'b0);  chk("pu_done_e33", bus.seq_done, 1'b1);
        chk("pu_to_e33", bus.timeout, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog edge=%0d", edge_n);
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        rst = 1'b1;
        bus.mem_ready = 1'b1;
        bus.soft_rst_req = 1'b0;

        repeat (5) @(negedge clk);
        chk("rst_mem_hold", bus.rst_mem, 1'b1);
        chk("rst_periph_hold", bus.rst_periph, 1'b1);
        chk("rst_cpu_hold", bus.rst_cpu, 1'b1);
        chk("done_hold", bus.seq_done, 1'b0);
        release_rst();
        check_powerup();

        // mem_ready bouncing in RUN is ignored.
        bus.mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        bus.mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("run_bounce_done", bus.seq_done, 1'b1);
        chk("run_bounce_cpu", bus.rst_cpu, 1'b0);

        // Soft reset with stray requests during SOFT and PERIPH.
        pulse_soft(s);
        wait_abs(s);
        chk("soft_cpu_s", bus.rst_cpu, 1'b1); chk("soft_periph_s", bus.rst_periph, 1'b1);
        chk("soft_done_s", bus.seq_done, 1'b0); chk("soft_mem_s", bus.rst_mem, 1'b0);
        wait_abs(s + 10); pulse_soft(e0);
        wait_abs(s + 31); chk("soft_periph_s31", bus.rst_periph, 1'b1);
        wait_abs(s + 32); chk("soft_periph_s32", bus.rst_periph, 1'b0);
        wait_abs(s + 40); pulse_soft(e0);
        wait_abs(s + 47); chk("soft_cpu_s47", bus.rst_cpu, 1'b1);
        wait_abs(s + 48); chk("soft_cpu_s48", bus.rst_cpu, 1'b0);
        chk("soft_done_s48", bus.seq_done, 1'b1); chk("soft_mem_s48", bus.rst_mem, 1'b0);

        // Reset mid-SOFT, then mid-WAIT_MEM, then a clean power-up again.
        pulse_soft(s);
        wait_abs(s + 5);
        assert_rst("rst_in_soft");
        bus.mem_ready = 1'b0;
        release_rst();
        at(50);
        assert_rst("rst_in_wait");
        bus.mem_ready = 1'b1;
        release_rst();
        check_powerup();

        // SDRAM never ready: forced progress with sticky timeout.
        assert_rst("rst_pre_timeout");
        bus.mem_ready = 1'b0;
        release_rst();
        at(4111); chk("to_periph_4111", bus.rst_periph, 1'b1); chk("to_flag_4111", bus.timeout, 1'b0);
        at(4112); chk("to_periph_4112", bus.rst_periph, 1'b0); chk("to_flag_4112", bus.timeout, 1'b1);
        at(4127); chk("to_cpu_4127", bus.rst_cpu, 1'b1);
        at(4128); chk("to_cpu_4128", bus.rst_cpu, 1'b0); chk("to_done_4128", bus.seq_done, 1'b1);
        bus.mem_ready = 1'b1;
        pulse_soft(s);
        wait_abs(s + 48);
        chk("to_sticky_after_soft", bus.timeout, 1'b1);

        // mem_ready arriving mid-wait.
        assert_rst("rst_clears_timeout");
        bus.mem_ready = 1'b0;
        release_rst();
        at(99);  chk("ready_periph_99", bus.rst_periph, 1'b1);
        bus.mem_ready = 1'b1;
        at(100); chk("ready_periph_100", bus.rst_periph, 1'b0); chk("ready_to_100", bus.timeout, 1'b0);

        // mem_ready rising exactly on the timeout edge beats the timeout.
        assert_rst("rst_pre_edge");
        bus.mem_ready = 1'b0;
        release_rst();
        at(4111);
        bus.mem_ready = 1'b1;
        at(4112); chk("edge_periph_4112", bus.rst_periph, 1'b0); chk("edge_to_4112", bus.timeout, 1'b0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 399) == 0);
            bus.mem_ready = ($urandom_range(0, 3) != 0);
            bus.soft_rst_req = ($urandom_range(0, 24) == 0);
        end
        rst = 1'b0;
        bus.soft_rst_req = 1'b0;
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
